// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, memory-wait freeze with timeout trap.
// Control outputs are combinational from state and inputs; performance counters are registered and saturate.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             exmem_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERROR} state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d, wcnt_inc;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             freeze, redirect, load_use, rd_match;

  always_comb begin
    freeze   = ((state_q == ST_RUN) && mem_req_i && !mem_ready_i) ||
               ((state_q == ST_MEM_WAIT) && !mem_ready_i) ||
               (state_q == ST_ERROR);
    rd_match = (ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i));
    redirect = !freeze && ex_redirect_i;
    // A redirect discards the ID instruction, so its hazard no longer matters.
    load_use = !freeze && !redirect && ex_memread_i && (ex_rd_i != 5'd0) && rd_match;

    pc_write_o    = !freeze && !load_use;
    ifid_write_o  = !freeze && !load_use;
    idex_write_o  = !freeze;
    exmem_write_o = !freeze;
    ifid_flush_o  = redirect;
    idex_flush_o  = redirect || load_use;
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    wcnt_inc = wcnt_q + 1'b1;
    case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d = ST_RUN;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == TO_V) state_d = ST_ERROR;
        end
      end
      default: state_d = ST_ERROR;
    endcase

    stall_d = (!pc_write_o && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    flush_d = (redirect && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign err_o       = (state_q == ST_ERROR);
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a default instance and a TIMEOUT=4/CNT_W=4 instance share stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses2, memread, redir, mem_req, mem_ready;

  logic        pcw0, ifw0, idw0, exw0, iff0, idf0, err0;
  logic [15:0] stall0, flush0;
  logic        pcw1, ifw1, idw1, exw1, iff1, idf1, err1;
  logic [3:0]  stall1, flush1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(uses2),
    .ex_memread_i(memread), .ex_rd_i(ex_rd), .ex_redirect_i(redir), .mem_req_i(mem_req),
    .mem_ready_i(mem_ready), .pc_write_o(pcw0), .ifid_write_o(ifw0), .idex_write_o(idw0),
    .exmem_write_o(exw0), .ifid_flush_o(iff0), .idex_flush_o(idf0), .err_o(err0),
    .stall_cnt_o(stall0), .flush_cnt_o(flush0));

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(uses2),
    .ex_memread_i(memread), .ex_rd_i(ex_rd), .ex_redirect_i(redir), .mem_req_i(mem_req),
    .mem_ready_i(mem_ready), .pc_write_o(pcw1), .ifid_write_o(ifw1), .idex_write_o(idw1),
    .exmem_write_o(exw1), .ifid_flush_o(iff1), .idex_flush_o(idf1), .err_o(err1),
    .stall_cnt_o(stall1), .flush_cnt_o(flush1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a memory stall becomes an error after TIMEOUT+1 consecutive unready cycles.
  int tmo[2]  = '{16, 4};
  int cmax[2] = '{65535, 15};
  int streak[2], merr[2], mstall[2], mflush[2];
  int n_streak[2], n_err[2], n_stall[2], n_flush[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic frozen, rdr, lu, pcw;
      logic [6:0] exp_f, act_f;
      logic [31:0] act_s, act_fl;
      if (!rst_i) begin
        streak[i] = 0; merr[i] = 0; mstall[i] = 0; mflush[i] = 0;
      end
      frozen = (merr[i] != 0) || (((streak[i] > 0) || mem_req) && !mem_ready);
      rdr    = !frozen && redir;
      lu     = !frozen && !rdr && memread && (ex_rd != 0) &&
               ((ex_rd == id_rs1) || (uses2 && ex_rd == id_rs2));
      pcw    = !frozen && !lu;
      exp_f  = {pcw, pcw, !frozen, !frozen, rdr, rdr || lu, merr[i] != 0};
      if (i == 0) begin
        act_f = {pcw0, ifw0, idw0, exw0, iff0, idf0, err0};
        act_s = 32'(stall0); act_fl = 32'(flush0);
      end else begin
        act_f = {pcw1, ifw1, idw1, exw1, iff1, idf1, err1};
        act_s = 32'(stall1); act_fl = 32'(flush1);
      end
      chk(i == 0 ? "model_flags0" : "model_flags1", 32'(act_f), 32'(exp_f));
      chk(i == 0 ? "model_stall0" : "model_stall1", act_s, mstall[i]);
      chk(i == 0 ? "model_flush0" : "model_flush1", act_fl, mflush[i]);
      n_err[i]    = merr[i];
      n_streak[i] = frozen ? streak[i] + 1 : 0;
      if (merr[i] == 0 && n_streak[i] == tmo[i] + 1) n_err[i] = 1;
      n_stall[i] = (!pcw && mstall[i] < cmax[i]) ? mstall[i] + 1 : mstall[i];
      n_flush[i] = (rdr && mflush[i] < cmax[i]) ? mflush[i] + 1 : mflush[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_i) begin
        streak[i] = 0; merr[i] = 0; mstall[i] = 0; mflush[i] = 0;
      end else begin
        streak[i] = n_streak[i]; merr[i] = n_err[i];
        mstall[i] = n_stall[i];  mflush[i] = n_flush[i];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; uses2 = 0; memread = 0;
    redir = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic reset_pulse();
    cyc();
    idle();
    rst_i = 1'b0;
    cyc();
    rst_i = 1'b1;
  endtask

  // {memread, rd, rs1, rs2, uses2, redirect, mem_req, mem_ready}
  logic [24:0] vec[8] = '{
    {1'b1, 5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0},
    {1'b1, 5'd3, 5'd4, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0},
    {1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0},
    {1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1},
    {1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0},
    {1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1},
    {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0},
    {1'b1, 5'd31, 5'd1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  initial begin
    idle();
    rst_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b1;
    @(negedge clk);
    chk("reset_err", 32'(err0), 0);
    chk("reset_stall", 32'(stall0), 0);
    chk("reset_flush", 32'(flush0), 0);
    chk("reset_pcw", 32'(pcw0), 1);

    // Load-use on rs1
    cyc(); memread = 1; ex_rd = 5; id_rs1 = 5;
    @(negedge clk);
    chk("lu_pcw", 32'(pcw0), 0);
    chk("lu_ifw", 32'(ifw0), 0);
    chk("lu_idf", 32'(idf0), 1);
    cyc(); idle();
    @(negedge clk);
    chk("lu_stall_cnt", 32'(stall0), 1);

    // rd=0 never stalls; rs2 only matters when used
    cyc(); memread = 1; ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    chk("rd0_pcw", 32'(pcw0), 1);
    chk("rd0_idf", 32'(idf0), 0);
    cyc(); ex_rd = 7; id_rs1 = 3; id_rs2 = 7; uses2 = 1;
    @(negedge clk);
    chk("rs2_pcw", 32'(pcw0), 0);
    cyc(); uses2 = 0;
    @(negedge clk);
    chk("rs2_unused_pcw", 32'(pcw0), 1);
    cyc(); idle();
    @(negedge clk);
    chk("rs2_stall_cnt", 32'(stall0), 2);

    // Redirect beats load-use
    reset_pulse();
    memread = 1; ex_rd = 5; id_rs1 = 5; redir = 1;
    @(negedge clk);
    chk("rd_iff", 32'(iff0), 1);
    chk("rd_idf", 32'(idf0), 1);
    chk("rd_pcw", 32'(pcw0), 1);
    cyc(); idle();
    @(negedge clk);
    chk("rd_flush_cnt", 32'(flush0), 1);
    chk("rd_stall_cnt", 32'(stall0), 0);

    // Three-cycle memory wait; redirect held during freeze is not counted
    reset_pulse();
    mem_req = 1; mem_ready = 0; redir = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mw_pcw", 32'(pcw0), 0);
      chk("mw_exw", 32'(exw0), 0);
      chk("mw_iff", 32'(iff0), 0);
      cyc();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("mw_release_pcw", 32'(pcw0), 1);
    chk("mw_release_exw", 32'(exw0), 1);
    cyc(); idle();
    @(negedge clk);
    chk("mw_stall_cnt", 32'(stall0), 3);
    chk("mw_flush_cnt", 32'(flush0), 1);
    chk("mw_run_pcw", 32'(pcw0), 1);

    // Timeout: small instance traps after 5 unready cycles, default keeps waiting
    reset_pulse();
    mem_req = 1; mem_ready = 0;
    repeat (4) cyc();
    @(negedge clk);
    chk("to_not_yet", 32'(err1), 0);
    cyc();
    @(negedge clk);
    chk("to_err_small", 32'(err1), 1);
    repeat (3) cyc();
    @(negedge clk);
    chk("to_err_default", 32'(err0), 0);
    chk("to_frozen_small", 32'(pcw1), 0);
    cyc(); mem_ready = 1;
    @(negedge clk);
    chk("to_sticky_err", 32'(err1), 1);
    chk("to_sticky_pcw", 32'(pcw1), 0);
    chk("to_default_release", 32'(pcw0), 1);
    cyc(); idle();
    @(negedge clk);
    chk("to_idle_err", 32'(err1), 1);
    reset_pulse();
    @(negedge clk);
    chk("to_reset_err", 32'(err1), 0);
    chk("to_reset_stall", 32'(stall1), 0);
    chk("to_reset_flush", 32'(flush1), 0);
    chk("to_reset_pcw", 32'(pcw1), 1);

    // Counter saturation
    cyc(); memread = 1; ex_rd = 5; id_rs1 = 5;
    repeat (20) cyc();
    idle();
    @(negedge clk);
    chk("sat_small", 32'(stall1), 15);
    chk("sat_default", 32'(stall0), 20);

    // Mixed directed vectors, checked by the model
    for (int v = 0; v < 8; v++) begin
      cyc();
      {memread, ex_rd, id_rs1, id_rs2, uses2, redir, mem_req, mem_ready} = vec[v];
    end
    cyc(); idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
